// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES encryption core.
//   fsm_t      - controller states (IDLE, ROUND, DONE)
//   RND_W      - width of the round counter (holds up to 14)
//   xtime      - multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   mix_column - MixColumns on one 32-bit column, row 0 in the top byte
//   rcon       - round constant for a 1-based index, derived by repeated xtime
//   aes_nr     - number of rounds for a given key length
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam int RND_W = 4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // rcon(1)=01, each further index doubles in GF(2^8): ... 80, 1b, 36.
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i <= 10; i++) begin
      if (i <= int'(idx)) r = xtime(r);
    end
    return r;
  endfunction

  function automatic int aes_nr(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational forward AES S-box.
//   a - input byte
//   y - substituted byte
// Computes the multiplicative inverse as a^254 (product of a^2, a^4 .. a^128),
// then applies the FIPS-197 affine transform. Zero maps to 0x63 because the
// power chain yields 0 for a zero input.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ xx;
      xx = xtime(xx);
    end
    return p;
  endfunction

  logic [7:0] sq [8];
  logic [7:0] inv;

  always_comb begin
    sq[0] = a;
    for (int i = 1; i < 8; i++) sq[i] = gf_mul(sq[i-1], sq[i-1]);
    inv = sq[1];
    for (int i = 2; i < 8; i++) inv = gf_mul(inv, sq[i]);
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/AES-256 encryption, one round per clock,
// with on-the-fly key expansion.
//   clk, rst         - clock, asynchronous active-high reset
//   in_valid/ready   - plaintext/key handshake; ready only while idle
//   in               - plaintext, in[127:120] is byte 0
//   encrypkey        - cipher key, top byte is key byte 0
//   out_valid/ready  - ciphertext handshake
//   out              - ciphertext while out_valid, otherwise zero
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in,
  input  logic [KEY_BITS-1:0] encrypkey,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out
);

  localparam int NR = aes_nr(KEY_BITS);

  fsm_t                fsm;
  logic [RND_W-1:0]    rnd;
  logic [127:0]        st;
  logic [KEY_BITS-1:0] key;

  logic [127:0] sb, sr, mc, rk, round_out;
  logic [127:0] base, new4;
  logic [31:0]  sw_in, sw_out, kt, n0, n1, n2, n3;
  logic [RND_W-1:0]    rc_idx;
  logic                use_rot;
  logic [KEY_BITS-1:0] key_next;

  // State SubBytes: byte position does not matter, so map lane to lane.
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a(st[8*i +: 8]), .y(sb[8*i +: 8]));
  end

  // SubWord for the key schedule.
  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sbox (.a(sw_in[8*j +: 8]), .y(sw_out[8*j +: 8]));
  end

  // The oldest four words of the key register are the XOR base for the
  // next four words; the newest word feeds RotWord/SubWord.
  assign base  = key[KEY_BITS-1 -: 128];
  assign sw_in = use_rot ? {key[23:0], key[31:24]} : key[31:0];

  if (KEY_BITS == 128) begin : g_k128
    assign use_rot  = 1'b1;
    assign rc_idx   = rnd;
    assign rk       = new4;
    assign key_next = new4;
  end else if (KEY_BITS == 256) begin : g_k256
    // Round 1 uses key words 4..7 directly; from round 2 even rounds
    // apply RotWord+Rcon, odd rounds SubWord only.
    assign use_rot  = ~rnd[0];
    assign rc_idx   = rnd >> 1;
    assign rk       = (rnd == RND_W'(1)) ? key[127:0] : new4;
    assign key_next = (rnd == RND_W'(1)) ? key : {key[127:0], new4};
  end else begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  always_comb begin
    kt   = sw_out ^ (use_rot ? {rcon(rc_idx), 24'h000000} : 32'h0);
    n0   = base[127:96] ^ kt;
    n1   = base[95:64]  ^ n0;
    n2   = base[63:32]  ^ n1;
    n3   = base[31:0]   ^ n2;
    new4 = {n0, n1, n2, n3};
  end

  // Byte k sits at row k%4, column k/4; ShiftRows moves row r left by r.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    round_out = ((rnd == RND_W'(NR)) ? sr : mc) ^ rk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
      rnd <= '0;
      st  <= '0;
      key <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            key <= encrypkey;
            st  <= in ^ encrypkey[KEY_BITS-1 -: 128];
            rnd <= RND_W'(1);
            fsm <= ROUND;
          end
        end
        ROUND: begin
          st  <= round_out;
          key <= key_next;
          if (rnd == RND_W'(NR)) fsm <= DONE;
          else                   rnd <= rnd + RND_W'(1);
        end
        DONE: begin
          if (out_ready) begin
            fsm <= IDLE;
            rnd <= '0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Outputs decode from registers only, so reset clears them immediately.
  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign out       = out_valid ? st : 128'h0;

endmodule
